// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data BRAM between the CPU (port 0) and a loader/debug master (port 1).
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 4
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic                    p0_valid,
  output logic                    p0_ready,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_byte_we,
  output logic                    p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_valid,
  output logic                    p1_ready,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_byte_we,
  output logic                    p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_we,
  output logic                    mem_r_en,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t     state;
  logic [3:0] hold_cnt;
  logic       last_winner, rsp_rd, g0, g1, hold_ok, again;
  assign hold_ok = hold_cnt < 4'(MAX_HOLD);
  always_comb begin
    g0 = state == OWN0 ? p0_valid & (!p1_valid | hold_ok)
       : state == OWN1 ? p0_valid & !(p1_valid & hold_ok)
       : p0_valid & (!p1_valid | last_winner);
    g1 = p1_valid & !g0;
    again = (g0 && state == OWN0) || (g1 && state == OWN1);
  end
  assign p0_ready    = g0;
  assign p1_ready    = g1;
  assign mem_addr    = g1 ? p1_addr : p0_addr;
  assign mem_wdata   = g1 ? p1_wdata : p0_wdata;
  assign mem_byte_we = g1 ? p1_byte_we : g0 ? p0_byte_we : '0;
  assign mem_r_en    = g1 ? ~|p1_byte_we : g0 & ~|p0_byte_we;
  always_ff @(posedge sysclk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      last_winner  <= 1'b1;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      rsp_rd       <= 1'b0;
    end else begin
      state        <= g0 ? OWN0 : g1 ? OWN1 : IDLE;
      last_winner  <= (g0 | g1) ? g1 : last_winner;
      hold_cnt     <= !(g0 | g1) ? 4'd0 : !again ? 4'd1 : hold_ok ? hold_cnt + 4'd1 : hold_cnt;
      p0_rsp_valid <= g0;
      p1_rsp_valid <= g1;
      rsp_rd       <= mem_r_en;
    end
  // BRAM data arrives in the response cycle, so read data is steered rather than registered
  assign p0_rdata = (p0_rsp_valid & rsp_rd) ? mem_rdata : '0;
  assign p1_rdata = (p1_rsp_valid & rsp_rd) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic against a shadow-memory reference of the arbitration rules.
module tb_dmem_arbiter;
  localparam int MAX = 4;
  logic        sysclk = 0, rst = 0;
  logic        p0_valid, p0_ready, p0_rsp_valid, p1_valid, p1_ready, p1_rsp_valid, mem_r_en;
  logic [11:0] p0_addr, p1_addr, mem_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [3:0]  p0_byte_we, p1_byte_we, mem_byte_we;
  logic        rv[2];
  logic [11:0] ra[2];
  logic [31:0] rd[2];
  logic [3:0]  rwe[2];
  logic        acc[2];
  logic [31:0] bram[4096], shadow[4096];
  logic [31:0] exp_data, old;
  int          exp_port = -1, prev_acc = -1, streak = 0, last_w = 1, wt[2];
  int          n_cmp = 0, n_bad = 0;
  dmem_arbiter dut (
    .sysclk(sysclk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_byte_we(p0_byte_we), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_byte_we(p1_byte_we), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_we(mem_byte_we),
    .mem_r_en(mem_r_en), .mem_rdata(mem_rdata)
  );
  assign p0_valid = rv[0];
  assign p0_addr = ra[0];
  assign p0_wdata = rd[0];
  assign p0_byte_we = rwe[0];
  assign p1_valid = rv[1];
  assign p1_addr = ra[1];
  assign p1_wdata = rd[1];
  assign p1_byte_we = rwe[1];
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) begin
    if (mem_r_en) mem_rdata <= bram[mem_addr];
    for (int b = 0; b < 4; b++)
      if (mem_byte_we[b]) bram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    exp_port = -1;
    prev_acc = -1;
    streak = 0;
    last_w = 1;
    wt[0] = 0;
    wt[1] = 0;
  endtask
  task automatic set_req(input int n, input logic v, input logic [11:0] a, input logic [31:0] d, input logic [3:0] we);
    rv[n] = v;
    ra[n] = a;
    rd[n] = d;
    rwe[n] = we;
  endtask
  // One clock: check DUT against the reference at the falling edge, then advance the reference.
  task automatic step();
    int eg;
    logic [11:0] a;
    logic [3:0] we;
    @(negedge sysclk);
    if (rv[0] && rv[1]) eg = prev_acc < 0 ? 1 - last_w : (streak < MAX ? prev_acc : 1 - prev_acc);
    else eg = rv[0] ? 0 : rv[1] ? 1 : -1;
    check("ready0", p0_ready, eg == 0);
    check("ready1", p1_ready, eg == 1);
    check("rsp0", p0_rsp_valid, exp_port == 0);
    check("rsp1", p1_rsp_valid, exp_port == 1);
    check("rdata0", p0_rdata, exp_port == 0 ? exp_data : 32'd0);
    check("rdata1", p1_rdata, exp_port == 1 ? exp_data : 32'd0);
    wt[0] = (rv[0] && !p0_ready) ? wt[0] + 1 : 0;
    wt[1] = (rv[1] && !p1_ready) ? wt[1] + 1 : 0;
    if (rv[0]) check("starve0", wt[0] <= MAX, 1);
    if (rv[1]) check("starve1", wt[1] <= MAX, 1);
    acc[0] = eg == 0;
    acc[1] = eg == 1;
    if (eg >= 0) begin
      a = ra[eg];
      we = rwe[eg];
      check("mem_addr", mem_addr, a);
      check("mem_r_en", mem_r_en, we == 0);
      check("mem_byte_we", mem_byte_we, we);
      exp_data = we == 0 ? shadow[a] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (we[b]) shadow[a][8*b+:8] = rd[eg][8*b+:8];
      streak = eg == prev_acc ? (streak < MAX ? streak + 1 : streak) : 1;
      last_w = eg;
    end else begin
      check("idle_mem", {mem_r_en, mem_byte_we}, 0);
      streak = 0;
    end
    exp_port = eg;
    prev_acc = eg;
    @(posedge sysclk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      bram[i] = $urandom;
      shadow[i] = bram[i];
    end
    bram[16] = 32'hDEADBEEF;
    shadow[16] = 32'hDEADBEEF;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge sysclk);
    #1 rst = 1;
    check("rst_rsp0", p0_rsp_valid, 0);
    check("rst_rsp1", p1_rsp_valid, 0);
    check("rst_rdata0", p0_rdata, 0);
    set_req(0, 1, 12'h010, 0, 0);
    step();
    check("t1_inflight", p0_rsp_valid, 1);
    set_req(0, 0, 0, 0, 0);
    rst = 0;
    #1;
    check("t1_rsp0", p0_rsp_valid, 0);
    check("t1_rdata0", p0_rdata, 0);
    @(posedge sysclk);
    #1;
    check("t1_stale", p0_rsp_valid | p1_rsp_valid, 0);
    rst = 1;
    model_reset();
    set_req(0, 1, 12'h001, 0, 0);
    set_req(1, 1, 12'h002, 0, 0);
    step();
    check("t3_first_p0", {p0_rsp_valid, p1_rsp_valid}, 2'b10);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    set_req(0, 1, 12'h001, 0, 0);
    set_req(1, 1, 12'h002, 0, 0);
    step();
    check("t3_second_p1", {p0_rsp_valid, p1_rsp_valid}, 2'b01);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    set_req(0, 1, 12'h003, 0, 0);
    set_req(1, 1, 12'h005, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_owner", {p0_rsp_valid, p1_rsp_valid}, i == 4 ? 2'b01 : 2'b10);
      set_req(0, 1, 12'(i + 6), 0, 0);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    set_req(0, 1, 12'h010, 0, 0);
    step();
    check("t2_rsp", p0_rsp_valid, 1);
    check("t2_rdata", p0_rdata, 32'hDEADBEEF);
    old = shadow[32];
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 12'h020, 32'h00000055, 4'b0001);
    step();
    check("t5_ack", {p1_rsp_valid, p1_rdata}, {1'b1, 32'd0});
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 12'h020, 0, 0);
    step();
    check("t5_rdata", p0_rdata, {old[31:8], 8'h55});
    for (int i = 0; i < 3; i++) begin
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      set_req(i % 2, 1, 12'(i), 0, 0);
      step();
      check("t6_route", {p0_rsp_valid, p1_rsp_valid}, i % 2 ? 2'b01 : 2'b10);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < 2; n++)
        if (!rv[n] || acc[n])
          set_req(n, $urandom_range(0, 2) != 0, 12'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) ? 4'($urandom) : 4'd0);
      step();
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
